clk_gen_multi: RTL and testbench

Parametrised multi-channel successor to the single-channel toggle clock divider. It generates NUM_CH independent divided clocks from one system clock, each with its own divisor and enable. Divisor changes take effect only at period boundaries, and enable start/stop is glitch-free. Software drives the divisors and enables through a CSR wrapper. The outputs feed peripheral serial interfaces (SPI/I2C SCL/UART baud) and the PWM module.

---
 rtl/clk_gen_multi.sv | 148 ++++++++++++++
 tb/tb_clk_gen_multi.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gen_multi.sv
// clk_gen_multi -- NUM_CH independent toggle clock dividers driven from clk_i.
//
// Each channel runs a small IDLE/RUN/STOPPING state machine with an up-counter
// and a shadow copy of its divisor. Half period is (shadow+1) clk_i cycles.
// The shadow reloads only on IDLE->RUN and on the high->low toggle, so divisor
// writes never produce runt phases. Dropping the enable while the output is
// high lets the high phase finish at full length before the channel parks low.
//
// Optional feature (macro CLK_GEN_SYNC_EN): adds sync_i, a one-cycle pulse
// that restarts every enabled channel from phase zero in the same cycle and
// idles every disabled channel immediately.
module clk_gen_multi #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
) (
   input  logic                    clk_i,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       en_i,
   input  logic [NUM_CH*CNT_W-1:0] div_i,
`ifdef CLK_GEN_SYNC_EN
   input  logic                    sync_i,
`endif
   output logic [NUM_CH-1:0]       clk_o,
   output logic [NUM_CH-1:0]       tick_o,
   output logic [NUM_CH-1:0]       active_o
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } state_e;

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch

      state_e           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] shadow_q, shadow_d;
      logic             clk_q, clk_d;
      logic             tick_q, tick_d;

      logic [CNT_W-1:0] div_n;
      logic             en_n;
      logic             at_limit;

      assign div_n    = div_i[n*CNT_W +: CNT_W];
      assign en_n     = en_i[n];
      // The counter never passes shadow, so equality marks the end of a phase.
      assign at_limit = (cnt_q == shadow_q);

      // Next-state, counter, divisor shadow and output level for this channel.
      always_comb begin
         // NOTE: every signal written here gets a default first; a path that
         // skipped one would leave it holding its value and infer a latch.
         state_d  = state_q;
         cnt_d    = cnt_q;
         shadow_d = shadow_q;
         clk_d    = clk_q;

         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               clk_d = 1'b0;
               if (en_n) begin
                  shadow_d = div_n;
                  state_d  = ST_RUN;
               end
            end

            ST_RUN, ST_STOPPING: begin
               // Free-running half-period counter.
               if (at_limit) begin
                  clk_d = ~clk_q;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end

               // The high->low toggle is the period boundary: pick up a new divisor.
               if (at_limit && clk_q) begin
                  shadow_d = div_n;
               end

               if (!en_n && !clk_q) begin
                  // Output already low: park at once, suppressing any pending rise.
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  clk_d   = 1'b0;
               end else if (!en_n) begin
                  // Output high: finish the high phase, then park on the fall.
                  state_d = at_limit ? ST_IDLE : ST_STOPPING;
               end else begin
                  // Enabled (or re-enabled while stopping): keep phase untouched.
                  state_d = ST_RUN;
               end
            end

            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               clk_d   = 1'b0;
            end
         endcase

`ifdef CLK_GEN_SYNC_EN
         // Sync overrides toggle, reload and stop logic in the same cycle.
         if (sync_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (en_n) begin
               shadow_d = div_n;
               state_d  = ST_RUN;
            end else begin
               state_d  = ST_IDLE;
            end
         end
`endif

         // Strobe exactly on the cycle the registered output first reads high.
         tick_d = clk_d & ~clk_q;
      end

      // Channel state register; everything clears asynchronously on reset.
      always_ff @(posedge clk_i or posedge reset) begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values computed above, independent of statement order.
         if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
         end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
         end
      end

      assign clk_o[n]    = clk_q;
      assign tick_o[n]   = tick_q;
      assign active_o[n] = (state_q != ST_IDLE);

   end : g_ch

endmodule : clk_gen_multi

// File: tb/tb_clk_gen_multi.sv
// Self-checking bench for clk_gen_multi (NUM_CH=4, CNT_W=16).
// A reference model tracks each channel as "on / level / cycles left in this
// phase" and is compared against the DUT after every clock edge; a hand-built
// table and directed sequences cover the start-up, divisor-update, stop,
// reset and extreme-divisor cases. Sync checks exist when CLK_GEN_SYNC_EN is set.
module tb_clk_gen_multi;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 16;

   logic                    clk;
   logic                    rst;
   logic [NUM_CH-1:0]       en_r;
   logic [NUM_CH*CNT_W-1:0] div_r;
   logic                    sync_r;
   logic [NUM_CH-1:0]       clk_o;
   logic [NUM_CH-1:0]       tick_o;
   logic [NUM_CH-1:0]       active_o;

   int n_vec;
   int n_bad;

   // Reference model state per channel.
   bit     m_on   [NUM_CH];
   bit     m_lvl  [NUM_CH];
   bit     m_tick [NUM_CH];
   longint m_rem  [NUM_CH];
   longint m_hp   [NUM_CH];

   typedef struct {
      logic [NUM_CH-1:0] en;
      logic [CNT_W-1:0]  div0;
      logic [NUM_CH-1:0] exp_clk;
      logic [NUM_CH-1:0] exp_tick;
      logic [NUM_CH-1:0] exp_act;
   } vec_t;

   vec_t tbl [19];

   clk_gen_multi #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk_i    (clk),
      .reset    (rst),
      .en_i     (en_r),
      .div_i    (div_r),
`ifdef CLK_GEN_SYNC_EN
      .sync_i   (sync_r),
`endif
      .clk_o    (clk_o),
      .tick_o   (tick_o),
      .active_o (active_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_on[c]   = 1'b0;
         m_lvl[c]  = 1'b0;
         m_tick[c] = 1'b0;
         m_rem[c]  = 0;
         m_hp[c]   = 1;
      end
   endtask

   // Advance the model by one clk_i edge using the inputs the DUT samples.
   task automatic model_update();
      for (int c = 0; c < NUM_CH; c++) begin
         bit     e;
         longint d;
         e = en_r[c];
         d = longint'(div_r[c*CNT_W +: CNT_W]);
         m_tick[c] = 1'b0;
`ifdef CLK_GEN_SYNC_EN
         if (sync_r) begin
            m_on[c]  = e;
            m_lvl[c] = 1'b0;
            m_hp[c]  = d + 1;
            m_rem[c] = d + 1;
            continue;
         end
`endif
         if (!m_on[c]) begin
            if (e) begin
               m_on[c]  = 1'b1;
               m_lvl[c] = 1'b0;
               m_hp[c]  = d + 1;
               m_rem[c] = m_hp[c];
            end
         end else if (!m_lvl[c] && !e) begin
            m_on[c] = 1'b0;
         end else begin
            m_rem[c]--;
            if (m_rem[c] == 0) begin
               if (m_lvl[c]) begin
                  m_lvl[c] = 1'b0;
                  m_hp[c]  = d + 1;
                  m_rem[c] = m_hp[c];
                  if (!e) m_on[c] = 1'b0;
               end else begin
                  m_lvl[c]  = 1'b1;
                  m_tick[c] = 1'b1;
                  m_rem[c]  = m_hp[c];
               end
            end
         end
      end
   endtask

   task automatic compare_model();
      logic [NUM_CH-1:0] e_clk, e_tick, e_act;
      for (int c = 0; c < NUM_CH; c++) begin
         e_clk[c]  = m_lvl[c];
         e_tick[c] = m_tick[c];
         e_act[c]  = m_on[c];
      end
      check("model_clk_o",    32'(clk_o),    32'(e_clk));
      check("model_tick_o",   32'(tick_o),   32'(e_tick));
      check("model_active_o", 32'(active_o), 32'(e_act));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_model();
   endtask

   task automatic wait_tick(input int ch, input int bound, output int n);
      bit ok;
      n  = 0;
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         step();
         n++;
         if (tick_o[ch]) begin
            ok = 1'b1;
            break;
         end
      end
      check("wait_tick_done", 32'(ok), 32'd1);
   endtask

   task automatic measure_phase(input int ch, input int bound, output int n);
      bit   ok;
      logic lvl;
      lvl = clk_o[ch];
      n   = 0;
      ok  = 1'b0;
      for (int i = 0; i < bound; i++) begin
         step();
         n++;
         if (clk_o[ch] !== lvl) begin
            ok = 1'b1;
            break;
         end
      end
      check("phase_end_seen", 32'(ok), 32'd1);
   endtask

   task automatic pulse_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
   endtask

   initial begin
      int n;
      int t1;
      bit ok;

      n_vec  = 0;
      n_bad  = 0;
      rst    = 1'b1;
      en_r   = '0;
      div_r  = '0;
      sync_r = 1'b0;
      model_reset();

      // Channel 0, div=3, enabled from reset: 4-cycle phases, then a stop while low.
      tbl[0]  = '{4'b0001, 16'd3, 4'b0000, 4'b0000, 4'b0001};
      tbl[1]  = '{4'b0001, 16'd3, 4'b0000, 4'b0000, 4'b0001};
      tbl[2]  = '{4'b0001, 16'd3, 4'b0000, 4'b0000, 4'b0001};
      tbl[3]  = '{4'b0001, 16'd3, 4'b0000, 4'b0000, 4'b0001};
      tbl[4]  = '{4'b0001, 16'd3, 4'b0001, 4'b0001, 4'b0001};
      tbl[5]  = '{4'b0001, 16'd3, 4'b0001, 4'b0000, 4'b0001};
      tbl[6]  = '{4'b0001, 16'd3, 4'b0001, 4'b0000, 4'b0001};
      tbl[7]  = '{4'b0001, 16'd3, 4'b0001, 4'b0000, 4'b0001};
      tbl[8]  = '{4'b0001, 16'd3, 4'b0000, 4'b0000, 4'b0001};
      tbl[9]  = '{4'b0001, 16'd3, 4'b0000, 4'b0000, 4'b0001};
      tbl[10] = '{4'b0001, 16'd3, 4'b0000, 4'b0000, 4'b0001};
      tbl[11] = '{4'b0001, 16'd3, 4'b0000, 4'b0000, 4'b0001};
      tbl[12] = '{4'b0001, 16'd3, 4'b0001, 4'b0001, 4'b0001};
      tbl[13] = '{4'b0001, 16'd3, 4'b0001, 4'b0000, 4'b0001};
      tbl[14] = '{4'b0001, 16'd3, 4'b0001, 4'b0000, 4'b0001};
      tbl[15] = '{4'b0001, 16'd3, 4'b0001, 4'b0000, 4'b0001};
      tbl[16] = '{4'b0001, 16'd3, 4'b0000, 4'b0000, 4'b0001};
      tbl[17] = '{4'b0000, 16'd3, 4'b0000, 4'b0000, 4'b0000};
      tbl[18] = '{4'b0000, 16'd3, 4'b0000, 4'b0000, 4'b0000};

      // Reset state.
      #2;
      check("rst_clk_o",    32'(clk_o),    32'd0);
      check("rst_tick_o",   32'(tick_o),   32'd0);
      check("rst_active_o", 32'(active_o), 32'd0);
      #10;
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         en_r            = tbl[i].en;
         div_r[CNT_W-1:0] = tbl[i].div0;
         step();
         check($sformatf("tbl%0d_clk_o", i),    32'(clk_o),    32'(tbl[i].exp_clk));
         check($sformatf("tbl%0d_tick_o", i),   32'(tick_o),   32'(tbl[i].exp_tick));
         check($sformatf("tbl%0d_active_o", i), 32'(active_o), 32'(tbl[i].exp_act));
      end

      // Divisor change 3->1 during the high phase: takes effect at the fall.
      en_r[0]          = 1'b1;
      div_r[CNT_W-1:0] = 16'd3;
      wait_tick(0, 40, n);
      step();
      div_r[CNT_W-1:0] = 16'd1;
      measure_phase(0, 20, n);
      check("chg_high_len", 32'(n + 1), 32'd4);
      measure_phase(0, 20, n);
      check("chg_low_len", 32'(n), 32'd2);
      measure_phase(0, 20, n);
      check("chg_next_high_len", 32'(n), 32'd2);

      // Park channel 0 before the stop tests.
      en_r[0] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!active_o[0]) break;
         step();
      end
      check("idle_reached", 32'(active_o[0]), 32'd0);

      // div=5, enable dropped at cnt=2 of the high phase: full 6-cycle high, then idle.
      en_r[0]          = 1'b1;
      div_r[CNT_W-1:0] = 16'd5;
      wait_tick(0, 40, n);
      step();
      step();
      en_r[0] = 1'b0;
      measure_phase(0, 20, n);
      check("stop_high_len", 32'(n + 2), 32'd6);
      check("stop_active",   32'(active_o[0]), 32'd0);

      // Re-enable during STOPPING: phase continues undisturbed.
      en_r[0] = 1'b1;
      wait_tick(0, 40, n);
      step();
      step();
      en_r[0] = 1'b0;
      step();
      check("stopping_active", 32'(active_o[0]), 32'd1);
      en_r[0] = 1'b1;
      measure_phase(0, 20, n);
      check("resume_high_len", 32'(n + 3), 32'd6);
      measure_phase(0, 20, n);
      check("resume_low_len", 32'(n), 32'd6);

      // Asynchronous reset in the middle of a high phase.
      step();
      check("pre_rst_high", 32'(clk_o[0]), 32'd1);
      pulse_reset();
      check("async_rst_clk_o",    32'(clk_o),    32'd0);
      check("async_rst_tick_o",   32'(tick_o),   32'd0);
      check("async_rst_active_o", 32'(active_o), 32'd0);
      #2;
      en_r             = 4'b0001;
      div_r[CNT_W-1:0] = 16'd3;
      rst              = 1'b0;
      wait_tick(0, 40, n);
      check("restart_first_rise", 32'(n - 1), 32'd4);

      // ch1 div=0 and ch2 div=0xFFFF enabled together.
      pulse_reset();
      div_r  = '0;
      div_r[2*CNT_W +: CNT_W] = 16'hFFFF;
      en_r   = 4'b0110;
      #2;
      rst = 1'b0;
      n   = 0;
      t1  = 0;
      ok  = 1'b0;
      for (int i = 0; i < 70000; i++) begin
         step();
         n++;
         if (tick_o[1]) t1++;
         if (tick_o[2]) begin
            ok = 1'b1;
            break;
         end
      end
      check("max_div_rise_seen", 32'(ok), 32'd1);
      check("max_div_first_rise", 32'(n - 1), 32'd65536);
      check("min_div_tick_count", 32'(t1), 32'd32768);

      // Randomised enables and divisors against the model.
      div_r = '0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            int c;
            c = int'($urandom_range(0, NUM_CH - 1));
            en_r[c] = ~en_r[c];
         end
         if ($urandom_range(0, 15) == 0) begin
            int c;
            c = int'($urandom_range(0, NUM_CH - 1));
            div_r[c*CNT_W +: CNT_W] = 16'($urandom_range(0, 6));
         end
         step();
      end

`ifdef CLK_GEN_SYNC_EN
      // Phase alignment: ch0 div=2, ch1 div=5, then a sync pulse.
      begin
         int f0;
         int f1;
         pulse_reset();
         div_r = '0;
         div_r[0 +: CNT_W]     = 16'd2;
         div_r[CNT_W +: CNT_W] = 16'd5;
         en_r  = 4'b0011;
         #2;
         rst = 1'b0;
         for (int i = 0; i < 17; i++) step();
         sync_r = 1'b1;
         step();
         sync_r = 1'b0;
         check("sync_clk_low",  32'(clk_o[1:0]),  32'd0);
         check("sync_tick_low", 32'(tick_o[1:0]), 32'd0);
         f0 = -1;
         f1 = -1;
         for (int i = 1; i <= 20; i++) begin
            step();
            if (tick_o[0] && f0 < 0) f0 = i;
            if (tick_o[1] && f1 < 0) f1 = i;
         end
         check("sync_ch0_first_rise", 32'(f0), 32'd3);
         check("sync_ch1_first_rise", 32'(f1), 32'd6);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_clk_gen_multi
